// File: rtl/pipeline_forward_ctrl_pkg.sv
// Shared forwarding-select encodings and register constants for the ID/EX forwarding logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_forward_ctrl_pkg;

    // EX operand mux select; the EX stage decodes the same values.
    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,   // value read from the register file
        FWD_MEMWB = 2'b01,   // value held in the MEM/WB register
        FWD_EXMEM = 2'b10    // value held in the EX/MEM register (newest)
    } fwd_sel_e;

    // Architectural zero register: writes to it are discarded, so it never forwards.
    localparam int unsigned REG_ZERO = 0;

    // True when either operand of an instruction takes a bypassed value.
    function automatic logic fwd_any(input fwd_sel_e a, input fwd_sel_e b);
        return (a != FWD_REG) || (b != FWD_REG);
    endfunction

endpackage

// File: rtl/pipeline_forward_ctrl_if.sv
// ID-stage decode fields in, EX forwarding selects / stall / counters out.
// Latency: n/a (wiring only).
// Backpressure: Stall is the only hold signal; it is combinational on the decode fields.
interface pipeline_forward_ctrl_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
);
    logic [RA_W-1:0]  ID_rs;
    logic [RA_W-1:0]  ID_rt;
    logic             ID_useRs;
    logic             ID_useRt;
    logic [RA_W-1:0]  ID_dest;
    logic             ID_RegWrite;
    logic             ID_MemRead;
    logic             Flush;
    logic [1:0]       ForwardA;
    logic [1:0]       ForwardB;
    logic             Stall;
    logic             EX_bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] fwd_cnt;

    // Decoder / branch unit side.
    modport master (
        output ID_rs, ID_rt, ID_useRs, ID_useRt, ID_dest, ID_RegWrite, ID_MemRead, Flush,
        input  ForwardA, ForwardB, Stall, EX_bubble, stall_cnt, fwd_cnt
    );

    // Forwarding controller side.
    modport slave (
        input  ID_rs, ID_rt, ID_useRs, ID_useRt, ID_dest, ID_RegWrite, ID_MemRead, Flush,
        output ForwardA, ForwardB, Stall, EX_bubble, stall_cnt, fwd_cnt
    );
endinterface

// File: rtl/pipeline_dep_cmp.sv
// Compares one ID source register against the EX and MEM shadow destinations.
// Latency: combinational.
// Backpressure: none; the caller decides whether an EX hit on a load stalls.
module pipeline_dep_cmp
    import pipeline_forward_ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] r,
    input  logic            rd_use,
    input  logic [RA_W-1:0] ex_dest,
    input  logic            ex_we,
    input  logic [RA_W-1:0] mem_dest,
    input  logic            mem_we,
    output fwd_sel_e        code,
    output logic            hit_ex
);

    logic hit_mem;

    // EX/MEM holds the newer value, so an EX hit takes priority over a MEM hit.
    always_comb begin
        hit_ex  = ex_we  && (ex_dest  != RA_W'(REG_ZERO)) && (ex_dest  == r);
        hit_mem = mem_we && (mem_dest != RA_W'(REG_ZERO)) && (mem_dest == r);
        code    = FWD_REG;
        if (rd_use) begin
            if (hit_ex) begin
                code = FWD_EXMEM;
            end else if (hit_mem) begin
                code = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/pipeline_forward_ctrl.sv
// Shadows ID/EX and EX/MEM destinations, computes forward selects in ID and registers them into EX.
// Latency: forward selects appear in EX one clock after the instruction was in ID.
// Backpressure: Stall (combinational) holds PC/IF-ID for one cycle on load-use; Flush overrides it.
module pipeline_forward_ctrl
    import pipeline_forward_ctrl_pkg::*;
#(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_forward_ctrl_if.slave fc
);

    // Shadow copy of the ID/EX register.
    logic [RA_W-1:0]  ex_dest_q,   ex_dest_d;
    logic             ex_we_q,     ex_we_d;
    logic             ex_ld_q,     ex_ld_d;
    // Shadow copy of the EX/MEM register.
    logic [RA_W-1:0]  mem_dest_q,  mem_dest_d;
    logic             mem_we_q,    mem_we_d;
    // Forward selects and bubble marker travelling with the instruction in EX.
    fwd_sel_e         fwd_a_q,     fwd_a_d;
    fwd_sel_e         fwd_b_q,     fwd_b_d;
    logic             ex_bubble_q, ex_bubble_d;
    // Performance counters, free-running and wrapping.
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] fwd_cnt_q,   fwd_cnt_d;

    fwd_sel_e code_a;
    fwd_sel_e code_b;
    logic     hit_ex_a;
    logic     hit_ex_b;
    logic     stall;
    logic     bubble;

    pipeline_dep_cmp #(.RA_W(RA_W)) u_cmp_rs (
        .r        (fc.ID_rs),
        .rd_use   (fc.ID_useRs),
        .ex_dest  (ex_dest_q),
        .ex_we    (ex_we_q),
        .mem_dest (mem_dest_q),
        .mem_we   (mem_we_q),
        .code     (code_a),
        .hit_ex   (hit_ex_a)
    );

    pipeline_dep_cmp #(.RA_W(RA_W)) u_cmp_rt (
        .r        (fc.ID_rt),
        .rd_use   (fc.ID_useRt),
        .ex_dest  (ex_dest_q),
        .ex_we    (ex_we_q),
        .mem_dest (mem_dest_q),
        .mem_we   (mem_we_q),
        .code     (code_b),
        .hit_ex   (hit_ex_b)
    );

    // Load-use hazard: the load's data is not ready until it reaches MEM. A flush kills the
    // consumer anyway, so it suppresses the stall; reset also forces it low.
    always_comb begin
        stall  = !reset && !fc.Flush && ex_ld_q &&
                 ((fc.ID_useRs && hit_ex_a) || (fc.ID_useRt && hit_ex_b));
        bubble = stall || fc.Flush;
    end

    // Next state: shift the shadow pipeline, load ID into EX or insert a bubble, bump counters.
    always_comb begin
        mem_dest_d  = ex_dest_q;
        mem_we_d    = ex_we_q;
        ex_dest_d   = fc.ID_dest;
        ex_we_d     = fc.ID_RegWrite;
        ex_ld_d     = fc.ID_MemRead;
        fwd_a_d     = code_a;
        fwd_b_d     = code_b;
        ex_bubble_d = 1'b0;
        stall_cnt_d = stall_cnt_q + CNT_W'(stall);
        fwd_cnt_d   = fwd_cnt_q;
        if (bubble) begin
            ex_we_d     = 1'b0;
            ex_ld_d     = 1'b0;
            fwd_a_d     = FWD_REG;
            fwd_b_d     = FWD_REG;
            ex_bubble_d = 1'b1;
        end else if (fwd_any(code_a, code_b)) begin
            fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset leaves an empty pipeline with a bubble in EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_dest_q   <= '0;
            ex_we_q     <= 1'b0;
            ex_ld_q     <= 1'b0;
            mem_dest_q  <= '0;
            mem_we_q    <= 1'b0;
            fwd_a_q     <= FWD_REG;
            fwd_b_q     <= FWD_REG;
            ex_bubble_q <= 1'b1;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            ex_dest_q   <= ex_dest_d;
            ex_we_q     <= ex_we_d;
            ex_ld_q     <= ex_ld_d;
            mem_dest_q  <= mem_dest_d;
            mem_we_q    <= mem_we_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            ex_bubble_q <= ex_bubble_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    // Output drive.
    always_comb begin
        fc.ForwardA  = fwd_a_q;
        fc.ForwardB  = fwd_b_q;
        fc.Stall     = stall;
        fc.EX_bubble = ex_bubble_q;
        fc.stall_cnt = stall_cnt_q;
        fc.fwd_cnt   = fwd_cnt_q;
    end

endmodule

// File: tb/tb_pipeline_forward_ctrl.sv
// Directed bench for pipeline_forward_ctrl: forwarding priority, load-use stall, $0, flush, reset.
// Latency: registered outputs are checked 1 time unit after the edge that loads EX.
// Backpressure: Stall is checked combinationally 1 time unit after the ID fields change.
module tb_pipeline_forward_ctrl;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    pipeline_forward_ctrl_if #(.RA_W(5), .CNT_W(32)) fc ();

    pipeline_forward_ctrl #(.RA_W(5), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .fc    (fc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic [4:0] dest, input logic we,
                         input logic ld);
        fc.ID_rs       = rs;
        fc.ID_rt       = rt;
        fc.ID_useRs    = urs;
        fc.ID_useRt    = urt;
        fc.ID_dest     = dest;
        fc.ID_RegWrite = we;
        fc.ID_MemRead  = ld;
        #1;
    endtask

    task automatic nop();
        issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        fc.Flush = 1'b0;
        nop();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        fc.Flush = 1'b0;
        nop();
        reset = 1'b1;
        step();
        total++; if (fc.ForwardA !== 2'b00) begin bad++; $display("FAIL rst_fa got=%b exp=00", fc.ForwardA); end
        total++; if (fc.ForwardB !== 2'b00) begin bad++; $display("FAIL rst_fb got=%b exp=00", fc.ForwardB); end
        total++; if (fc.EX_bubble !== 1'b1) begin bad++; $display("FAIL rst_bubble got=%b exp=1", fc.EX_bubble); end
        total++; if (fc.stall_cnt !== 32'd0) begin bad++; $display("FAIL rst_stall_cnt got=%0d exp=0", fc.stall_cnt); end
        total++; if (fc.fwd_cnt !== 32'd0) begin bad++; $display("FAIL rst_fwd_cnt got=%0d exp=0", fc.fwd_cnt); end
        total++; if (fc.Stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", fc.Stall); end
        reset = 1'b0;
    endtask

    // add $8,$1,$2 ; sub $9,$8,$3
    task automatic test_exmem_fwd();
        do_reset();
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        step();
        issue(5'd8, 5'd3, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        total++; if (fc.Stall !== 1'b0) begin bad++; $display("FAIL t1_stall got=%b exp=0", fc.Stall); end
        step();
        nop();
        total++; if (fc.ForwardA !== 2'b10) begin bad++; $display("FAIL t1_fa got=%b exp=10", fc.ForwardA); end
        total++; if (fc.ForwardB !== 2'b00) begin bad++; $display("FAIL t1_fb got=%b exp=00", fc.ForwardB); end
        total++; if (fc.EX_bubble !== 1'b0) begin bad++; $display("FAIL t1_bubble got=%b exp=0", fc.EX_bubble); end
        total++; if (fc.fwd_cnt !== 32'd1) begin bad++; $display("FAIL t1_fwd_cnt got=%0d exp=1", fc.fwd_cnt); end
    endtask

    // add $8 ; nop ; or $9,$4,$8
    task automatic test_memwb_fwd();
        do_reset();
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        step();
        nop();
        step();
        issue(5'd4, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        step();
        nop();
        total++; if (fc.ForwardA !== 2'b00) begin bad++; $display("FAIL t2_fa got=%b exp=00", fc.ForwardA); end
        total++; if (fc.ForwardB !== 2'b01) begin bad++; $display("FAIL t2_fb got=%b exp=01", fc.ForwardB); end
        total++; if (fc.fwd_cnt !== 32'd1) begin bad++; $display("FAIL t2_fwd_cnt got=%0d exp=1", fc.fwd_cnt); end
    endtask

    // lw $8,0($1) ; add $9,$8,$8
    task automatic test_load_use();
        do_reset();
        issue(5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        step();
        issue(5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        total++; if (fc.Stall !== 1'b1) begin bad++; $display("FAIL t3_stall got=%b exp=1", fc.Stall); end
        step();
        total++; if (fc.EX_bubble !== 1'b1) begin bad++; $display("FAIL t3_bubble got=%b exp=1", fc.EX_bubble); end
        total++; if (fc.stall_cnt !== 32'd1) begin bad++; $display("FAIL t3_stall_cnt got=%0d exp=1", fc.stall_cnt); end
        total++; if (fc.Stall !== 1'b0) begin bad++; $display("FAIL t3_stall_once got=%b exp=0", fc.Stall); end
        step();
        nop();
        total++; if (fc.ForwardA !== 2'b01) begin bad++; $display("FAIL t3_fa got=%b exp=01", fc.ForwardA); end
        total++; if (fc.ForwardB !== 2'b01) begin bad++; $display("FAIL t3_fb got=%b exp=01", fc.ForwardB); end
        total++; if (fc.EX_bubble !== 1'b0) begin bad++; $display("FAIL t3_bubble2 got=%b exp=0", fc.EX_bubble); end
        total++; if (fc.stall_cnt !== 32'd1) begin bad++; $display("FAIL t3_stall_cnt2 got=%0d exp=1", fc.stall_cnt); end
        total++; if (fc.fwd_cnt !== 32'd1) begin bad++; $display("FAIL t3_fwd_cnt got=%0d exp=1", fc.fwd_cnt); end
    endtask

    // addi $0,$0,5 ; add $9,$0,$0 ; lw $0 ; use of $0
    task automatic test_reg_zero();
        do_reset();
        issue(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        step();
        issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        step();
        total++; if (fc.ForwardA !== 2'b00) begin bad++; $display("FAIL t4_fa got=%b exp=00", fc.ForwardA); end
        total++; if (fc.ForwardB !== 2'b00) begin bad++; $display("FAIL t4_fb got=%b exp=00", fc.ForwardB); end
        total++; if (fc.fwd_cnt !== 32'd0) begin bad++; $display("FAIL t4_fwd_cnt got=%0d exp=0", fc.fwd_cnt); end
        issue(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
        step();
        issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        total++; if (fc.Stall !== 1'b0) begin bad++; $display("FAIL t4_stall got=%b exp=0", fc.Stall); end
        step();
        nop();
    endtask

    // add $8 ; add $8 ; add $9,$8,$1 ; lw $8 ; sw $8,4($2)
    task automatic test_newest_and_store();
        do_reset();
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        step();
        issue(5'd3, 5'd4, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        step();
        issue(5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        step();
        total++; if (fc.ForwardA !== 2'b10) begin bad++; $display("FAIL t5_fa_newest got=%b exp=10", fc.ForwardA); end
        total++; if (fc.ForwardB !== 2'b00) begin bad++; $display("FAIL t5_fb got=%b exp=00", fc.ForwardB); end
        issue(5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        step();
        issue(5'd2, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        total++; if (fc.Stall !== 1'b1) begin bad++; $display("FAIL t5_sw_stall got=%b exp=1", fc.Stall); end
        step();
        total++; if (fc.EX_bubble !== 1'b1) begin bad++; $display("FAIL t5_bubble got=%b exp=1", fc.EX_bubble); end
        total++; if (fc.Stall !== 1'b0) begin bad++; $display("FAIL t5_stall_once got=%b exp=0", fc.Stall); end
        step();
        nop();
        total++; if (fc.ForwardB !== 2'b01) begin bad++; $display("FAIL t5_sw_fb got=%b exp=01", fc.ForwardB); end
        total++; if (fc.ForwardA !== 2'b00) begin bad++; $display("FAIL t5_sw_fa got=%b exp=00", fc.ForwardA); end
        total++; if (fc.stall_cnt !== 32'd1) begin bad++; $display("FAIL t5_stall_cnt got=%0d exp=1", fc.stall_cnt); end
    endtask

    // lw $8 ; add $9,$8,$1 with Flush in the same cycle
    task automatic test_flush();
        do_reset();
        issue(5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        step();
        fc.Flush = 1'b1;
        issue(5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        total++; if (fc.Stall !== 1'b0) begin bad++; $display("FAIL t6_stall got=%b exp=0", fc.Stall); end
        step();
        fc.Flush = 1'b0;
        nop();
        total++; if (fc.EX_bubble !== 1'b1) begin bad++; $display("FAIL t6_bubble got=%b exp=1", fc.EX_bubble); end
        total++; if (fc.stall_cnt !== 32'd0) begin bad++; $display("FAIL t6_stall_cnt got=%0d exp=0", fc.stall_cnt); end
        total++; if (fc.ForwardA !== 2'b00) begin bad++; $display("FAIL t6_fa got=%b exp=00", fc.ForwardA); end
    endtask

    // add $8 ; sub $9,$8,$3 ; lw $8 ; then reset while a load-use consumer is in ID
    task automatic test_mid_reset();
        do_reset();
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        step();
        issue(5'd8, 5'd3, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        step();
        total++; if (fc.fwd_cnt !== 32'd1) begin bad++; $display("FAIL t7_pre_fwd_cnt got=%0d exp=1", fc.fwd_cnt); end
        issue(5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
        step();
        issue(5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        total++; if (fc.Stall !== 1'b1) begin bad++; $display("FAIL t7_pre_stall got=%b exp=1", fc.Stall); end
        reset = 1'b1;
        #1;
        total++; if (fc.Stall !== 1'b0) begin bad++; $display("FAIL t7_stall_in_reset got=%b exp=0", fc.Stall); end
        step();
        reset = 1'b0;
        total++; if (fc.ForwardA !== 2'b00) begin bad++; $display("FAIL t7_fa got=%b exp=00", fc.ForwardA); end
        total++; if (fc.ForwardB !== 2'b00) begin bad++; $display("FAIL t7_fb got=%b exp=00", fc.ForwardB); end
        total++; if (fc.fwd_cnt !== 32'd0) begin bad++; $display("FAIL t7_fwd_cnt got=%0d exp=0", fc.fwd_cnt); end
        total++; if (fc.stall_cnt !== 32'd0) begin bad++; $display("FAIL t7_stall_cnt got=%0d exp=0", fc.stall_cnt); end
        total++; if (fc.EX_bubble !== 1'b1) begin bad++; $display("FAIL t7_bubble got=%b exp=1", fc.EX_bubble); end
        nop();
        total++; if (fc.Stall !== 1'b0) begin bad++; $display("FAIL t7_post_stall got=%b exp=0", fc.Stall); end
    endtask

    initial begin
        clk      = 1'b0;
        reset    = 1'b1;
        total    = 0;
        bad      = 0;
        fc.Flush = 1'b0;
        nop();
        test_reset();
        test_exmem_fwd();
        test_memwb_fwd();
        test_load_use();
        test_reg_zero();
        test_newest_and_store();
        test_flush();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
